// File: rtl/ddr_cmd_scheduler_pkg.sv
// ddr_sched_pkg: command encodings shared by the DDR command scheduler.
// APP_CMD_WR / APP_CMD_RD are the app_cmd codes understood by the DDR core.
package ddr_sched_pkg;

    localparam logic [2:0] APP_CMD_WR = 3'b000;
    localparam logic [2:0] APP_CMD_RD = 3'b001;

endpackage : ddr_sched_pkg

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with storage held in flops.
// Ports:
//   clk, rst      - clock, synchronous active-high reset (flushes contents)
//   push, din     - write strobe and data (ignored when full)
//   pop           - remove head entry (ignored when empty)
//   dout          - head entry, valid while empty=0; stable until popped
//   full, empty   - occupancy flags
//   count         - number of stored entries (0..DEPTH)
// A pushed word becomes visible on dout the cycle after the push; there is
// no combinational path from din to dout.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr_reg];

    // DEPTH is a power of two, so the pointers wrap on natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            count_reg <= count_reg + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= din;
    end

endmodule : sync_fifo

// File: rtl/ddr_cmd_scheduler.sv
// ddr_cmd_scheduler: bridges a simple RAM command port onto a DDR app
// interface. Writes and read commands are issued to the core in the cycle
// they are accepted; read data is buffered and returned in issue order
// together with the ID/last tag captured when the read was issued.
// Ports:
//   clk, rst                    - clock, synchronous active-high reset
//   ram_cmd_*                   - command request (id, addr, wr data/strb,
//                                 wr_en, rd_en, last) and ram_cmd_ready
//   ram_rd_resp_*               - read response (id, data, last, valid/ready)
//   app_cmd_ready, app_wdf_rdy,
//   init_calib_complete         - DDR core status
//   app_cmd, app_cmd_en, app_addr, app_wdf_* - DDR core command/write channel
//   app_rd_data, app_rd_data_valid          - DDR core read return
//   outstanding                 - reads issued but not yet handed back
//   err                         - sticky protocol error (cleared by rst)
module ddr_cmd_scheduler
    import ddr_sched_pkg::*;
#(
    parameter int DATA_WIDTH     = 128,
    parameter int ADDR_WIDTH     = 32,
    parameter int ID_WIDTH       = 4,
    parameter int APP_ADDR_WIDTH = 29,
    parameter int ADDR_SHIFT     = 0,
    parameter int DEPTH          = 4,
    parameter bit WR_WAIT_RD     = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ID_WIDTH-1:0]       ram_cmd_id,
    input  logic [ADDR_WIDTH-1:0]     ram_cmd_addr,
    input  logic [DATA_WIDTH-1:0]     ram_cmd_wr_data,
    input  logic [DATA_WIDTH/8-1:0]   ram_cmd_wr_strb,
    input  logic                      ram_cmd_wr_en,
    input  logic                      ram_cmd_rd_en,
    input  logic                      ram_cmd_last,
    output logic                      ram_cmd_ready,
    output logic [ID_WIDTH-1:0]       ram_rd_resp_id,
    output logic [DATA_WIDTH-1:0]     ram_rd_resp_data,
    output logic                      ram_rd_resp_last,
    output logic                      ram_rd_resp_valid,
    input  logic                      ram_rd_resp_ready,
    input  logic                      app_cmd_ready,
    input  logic                      app_wdf_rdy,
    input  logic                      init_calib_complete,
    output logic [2:0]                app_cmd,
    output logic                      app_cmd_en,
    output logic [APP_ADDR_WIDTH-1:0] app_addr,
    output logic [DATA_WIDTH-1:0]     app_wdf_data,
    output logic [DATA_WIDTH/8-1:0]   app_wdf_mask,
    output logic                      app_wdf_wren,
    output logic                      app_wdf_end,
    input  logic [DATA_WIDTH-1:0]     app_rd_data,
    input  logic                      app_rd_data_valid,
    output logic [$clog2(DEPTH):0]    outstanding,
    output logic                      err
);

    localparam int OW = $clog2(DEPTH) + 1;
    localparam int TW = ID_WIDTH + 1;

    logic [OW-1:0]         outstanding_reg;
    logic                  err_reg;
    logic                  wr_ok;
    logic                  rd_ok;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  resp_hs;
    logic                  beat_ok;
    logic [ADDR_WIDTH-1:0] addr_shifted;
    logic [TW-1:0]         tag_din;
    logic [TW-1:0]         tag_dout;
    logic                  tag_full;
    logic                  tag_empty;
    logic [OW-1:0]         tag_count;
    logic                  data_full;
    logic                  data_empty;
    logic [OW-1:0]         data_count;

    // A write while a read is in flight is held back only when WR_WAIT_RD
    // asks for read/write ordering.
    assign wr_ok = init_calib_complete & app_cmd_ready & app_wdf_rdy &
                   (!WR_WAIT_RD || (outstanding_reg == '0));
    assign rd_ok = init_calib_complete & app_cmd_ready &
                   (outstanding_reg < OW'(DEPTH));

    // wr_en wins when both enables are high, so ready follows the write path.
    always_comb begin
        ram_cmd_ready = 1'b0;
        if (!rst) begin
            if (ram_cmd_wr_en)      ram_cmd_ready = wr_ok;
            else if (ram_cmd_rd_en) ram_cmd_ready = rd_ok;
        end
    end

    assign wr_acc = ram_cmd_wr_en & ram_cmd_ready;
    assign rd_acc = ram_cmd_rd_en & ~ram_cmd_wr_en & ram_cmd_ready;

    assign app_cmd      = rd_acc ? APP_CMD_RD : APP_CMD_WR;
    assign app_cmd_en   = wr_acc | rd_acc;
    assign app_wdf_wren = wr_acc;
    assign app_wdf_end  = wr_acc;
    assign app_wdf_data = ram_cmd_wr_data;

    assign addr_shifted = ram_cmd_addr >> ADDR_SHIFT;
    assign app_addr     = addr_shifted[APP_ADDR_WIDTH-1:0];

    // Mask is active-high "do not write", the inverse of the byte strobe.
    generate
        for (genvar gi = 0; gi < DATA_WIDTH/8; gi++) begin : g_mask
            assign app_wdf_mask[gi] = ~ram_cmd_wr_strb[gi];
        end
    endgenerate

    assign ram_rd_resp_valid = ~rst & ~data_empty;
    assign resp_hs           = ram_rd_resp_valid & ram_rd_resp_ready;

    // A beat is only legitimate if some issued read is still waiting for
    // data; otherwise (spurious beat, or one that outlived a reset) drop it.
    assign beat_ok = (data_count != outstanding_reg);

    assign tag_din = {ram_cmd_id, ram_cmd_last};

    sync_fifo #(.WIDTH(TW), .DEPTH(DEPTH)) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rd_acc),
        .din   (tag_din),
        .pop   (resp_hs),
        .dout  (tag_dout),
        .full  (tag_full),
        .empty (tag_empty),
        .count (tag_count)
    );

    sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_data_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (app_rd_data_valid & beat_ok),
        .din   (app_rd_data),
        .pop   (resp_hs),
        .dout  (ram_rd_resp_data),
        .full  (data_full),
        .empty (data_empty),
        .count (data_count)
    );

    assign ram_rd_resp_id   = tag_dout[TW-1:1];
    assign ram_rd_resp_last = tag_dout[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding_reg <= '0;
            err_reg         <= 1'b0;
        end else begin
            outstanding_reg <= outstanding_reg + OW'(rd_acc) - OW'(resp_hs);
            if ((ram_cmd_wr_en & ram_cmd_rd_en) | (app_rd_data_valid & ~beat_ok))
                err_reg <= 1'b1;
        end
    end

    assign outstanding = outstanding_reg;
    assign err         = err_reg;

endmodule : ddr_cmd_scheduler

// File: tb/tb_ddr_cmd_scheduler.sv
// Directed self-checking bench for ddr_cmd_scheduler (WR_WAIT_RD=1 so the
// write-after-read stall can be exercised; writes elsewhere occur with no
// reads in flight). Inputs change on the falling edge; outputs are sampled
// 1 ns later, well away from the rising edge.
module tb_ddr_cmd_scheduler;

    localparam int DW = 128;
    localparam int AW = 32;
    localparam int IW = 4;
    localparam int PW = 29;
    localparam int DP = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [IW-1:0]   ram_cmd_id;
    logic [AW-1:0]   ram_cmd_addr;
    logic [DW-1:0]   ram_cmd_wr_data;
    logic [DW/8-1:0] ram_cmd_wr_strb;
    logic            ram_cmd_wr_en;
    logic            ram_cmd_rd_en;
    logic            ram_cmd_last;
    logic            ram_cmd_ready;
    logic [IW-1:0]   ram_rd_resp_id;
    logic [DW-1:0]   ram_rd_resp_data;
    logic            ram_rd_resp_last;
    logic            ram_rd_resp_valid;
    logic            ram_rd_resp_ready;
    logic            app_cmd_ready;
    logic            app_wdf_rdy;
    logic            init_calib_complete;
    logic [2:0]      app_cmd;
    logic            app_cmd_en;
    logic [PW-1:0]   app_addr;
    logic [DW-1:0]   app_wdf_data;
    logic [DW/8-1:0] app_wdf_mask;
    logic            app_wdf_wren;
    logic            app_wdf_end;
    logic [DW-1:0]   app_rd_data;
    logic            app_rd_data_valid;
    logic [2:0]      outstanding;
    logic            err;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    ddr_cmd_scheduler #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .APP_ADDR_WIDTH(PW),
        .ADDR_SHIFT(0), .DEPTH(DP), .WR_WAIT_RD(1'b1)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .ram_cmd_id          (ram_cmd_id),
        .ram_cmd_addr        (ram_cmd_addr),
        .ram_cmd_wr_data     (ram_cmd_wr_data),
        .ram_cmd_wr_strb     (ram_cmd_wr_strb),
        .ram_cmd_wr_en       (ram_cmd_wr_en),
        .ram_cmd_rd_en       (ram_cmd_rd_en),
        .ram_cmd_last        (ram_cmd_last),
        .ram_cmd_ready       (ram_cmd_ready),
        .ram_rd_resp_id      (ram_rd_resp_id),
        .ram_rd_resp_data    (ram_rd_resp_data),
        .ram_rd_resp_last    (ram_rd_resp_last),
        .ram_rd_resp_valid   (ram_rd_resp_valid),
        .ram_rd_resp_ready   (ram_rd_resp_ready),
        .app_cmd_ready       (app_cmd_ready),
        .app_wdf_rdy         (app_wdf_rdy),
        .init_calib_complete (init_calib_complete),
        .app_cmd             (app_cmd),
        .app_cmd_en          (app_cmd_en),
        .app_addr            (app_addr),
        .app_wdf_data        (app_wdf_data),
        .app_wdf_mask        (app_wdf_mask),
        .app_wdf_wren        (app_wdf_wren),
        .app_wdf_end         (app_wdf_end),
        .app_rd_data         (app_rd_data),
        .app_rd_data_valid   (app_rd_data_valid),
        .outstanding         (outstanding),
        .err                 (err)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Advance to the next falling edge (state from the last rising edge is visible).
    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        ram_cmd_wr_en     = 1'b0;
        ram_cmd_rd_en     = 1'b0;
        app_rd_data_valid = 1'b0;
    endtask

    // Present a read for one cycle, check it is issued, then drop rd_en.
    task automatic issue_read(input logic [IW-1:0] id, input logic last);
        step();
        ram_cmd_rd_en = 1'b1;
        ram_cmd_id    = id;
        ram_cmd_last  = last;
        ram_cmd_addr  = 32'h0000_2000 + 32'(id) * 32'h40;
        #1;
        $display("read  id=%0d last=%0d ready=%0b app_cmd=%0d", id, last, ram_cmd_ready, app_cmd);
        chk("rd_ready", ram_cmd_ready, 1'b1);
        chk("rd_app_cmd", app_cmd, 3'b001);
        chk("rd_cmd_en", app_cmd_en, 1'b1);
        chk("rd_no_wren", app_wdf_wren, 1'b0);
        step();
        ram_cmd_rd_en = 1'b0;
    endtask

    // One-cycle read-data beat from the DDR core.
    task automatic beat(input logic [DW-1:0] d);
        step();
        app_rd_data_valid = 1'b1;
        app_rd_data       = d;
        step();
        app_rd_data_valid = 1'b0;
    endtask

    // Response is already at the head: check, handshake, release ready.
    task automatic take_resp(input logic [IW-1:0] id, input logic [DW-1:0] d, input logic last);
        #1;
        $display("resp  id=%0d last=%0d data=%0h", ram_rd_resp_id, ram_rd_resp_last, ram_rd_resp_data);
        chk("resp_valid", ram_rd_resp_valid, 1'b1);
        chk("resp_id", ram_rd_resp_id, id);
        chk("resp_data", ram_rd_resp_data, d);
        chk("resp_last", ram_rd_resp_last, last);
        ram_rd_resp_ready = 1'b1;
        step();
        ram_rd_resp_ready = 1'b0;
    endtask

    logic [DW-1:0] dat_a;
    logic [DW-1:0] dat_b;

    initial begin
        rst                 = 1'b1;
        ram_cmd_id          = '0;
        ram_cmd_addr        = '0;
        ram_cmd_wr_data     = '0;
        ram_cmd_wr_strb     = '0;
        ram_cmd_last        = 1'b0;
        ram_rd_resp_ready   = 1'b0;
        app_cmd_ready       = 1'b1;
        app_wdf_rdy         = 1'b1;
        init_calib_complete = 1'b1;
        app_rd_data         = '0;
        idle_inputs();
        dat_a = {32'hAAAA_0001, 32'h1111_2222, 32'h3333_4444, 32'h5555_6666};
        dat_b = {32'hBBBB_0002, 32'h7777_8888, 32'h9999_AAAA, 32'hCCCC_DDDD};

        // ---- reset: nothing accepted or presented while rst is high
        step();
        ram_cmd_rd_en = 1'b1;
        #1;
        chk("rst_ready", ram_cmd_ready, 1'b0);
        chk("rst_cmd_en", app_cmd_en, 1'b0);
        chk("rst_resp_valid", ram_rd_resp_valid, 1'b0);
        step();
        ram_cmd_rd_en = 1'b0;
        rst = 1'b0;
        step();
        #1;
        chk("post_rst_outstanding", outstanding, 3'd0);
        chk("post_rst_err", err, 1'b0);
        chk("post_rst_wren", app_wdf_wren, 1'b0);

        // ---- write: addr 0x100, full strobe
        step();
        ram_cmd_wr_en   = 1'b1;
        ram_cmd_addr    = 32'h0000_0100;
        ram_cmd_wr_strb = 16'hFFFF;
        ram_cmd_wr_data = dat_a;
        #1;
        $display("write addr=%0h strb=%0h ready=%0b", ram_cmd_addr, ram_cmd_wr_strb, ram_cmd_ready);
        chk("wr_ready", ram_cmd_ready, 1'b1);
        chk("wr_app_cmd", app_cmd, 3'b000);
        chk("wr_app_addr", app_addr, 29'h100);
        chk("wr_mask", app_wdf_mask, 16'h0000);
        chk("wr_end", app_wdf_end, 1'b1);
        chk("wr_wren", app_wdf_wren, 1'b1);
        chk("wr_cmd_en", app_cmd_en, 1'b1);
        chk("wr_data", app_wdf_data, dat_a);

        // ---- write: partial strobe and address truncated to 29 bits
        step();
        ram_cmd_addr    = 32'hABCD_1234;
        ram_cmd_wr_strb = 16'h00F0;
        ram_cmd_wr_data = dat_b;
        #1;
        $display("write addr=%0h strb=%0h ready=%0b", ram_cmd_addr, ram_cmd_wr_strb, ram_cmd_ready);
        chk("wr2_app_addr", app_addr, 29'h0BCD_1234);
        chk("wr2_mask", app_wdf_mask, 16'hFF0F);
        chk("wr2_data", app_wdf_data, dat_b);

        // ---- write stalled by app_wdf_rdy
        app_wdf_rdy = 1'b0;
        #1;
        chk("wr_wdf_stall_ready", ram_cmd_ready, 1'b0);
        chk("wr_wdf_stall_wren", app_wdf_wren, 1'b0);
        app_wdf_rdy = 1'b1;

        // ---- idle: strobes low
        step();
        ram_cmd_wr_en = 1'b0;
        #1;
        chk("idle_cmd_en", app_cmd_en, 1'b0);
        chk("idle_wren", app_wdf_wren, 1'b0);
        chk("idle_end", app_wdf_end, 1'b0);

        // ---- no acceptance before calibration
        step();
        init_calib_complete = 1'b0;
        ram_cmd_rd_en       = 1'b1;
        #1;
        chk("calib_ready", ram_cmd_ready, 1'b0);
        chk("calib_cmd_en", app_cmd_en, 1'b0);
        step();
        ram_cmd_rd_en       = 1'b0;
        init_calib_complete = 1'b1;
        #1;
        chk("calib_outstanding", outstanding, 3'd0);

        // ---- four reads fill the credits; a fifth waits for a handshake
        for (int i = 1; i <= 4; i++) issue_read(IW'(i), (i == 4));
        #1;
        chk("full_outstanding", outstanding, 3'd4);
        step();
        ram_cmd_rd_en = 1'b1;
        ram_cmd_id    = 4'd5;
        ram_cmd_last  = 1'b1;
        app_rd_data_valid = 1'b1;
        app_rd_data       = 128'h1;
        #1;
        chk("fifth_ready_blocked", ram_cmd_ready, 1'b0);
        chk("fifth_cmd_en", app_cmd_en, 1'b0);
        step();
        app_rd_data_valid = 1'b0;
        #1;
        chk("fifth_still_blocked", ram_cmd_ready, 1'b0);
        take_resp(4'd1, 128'h1, 1'b0);
        #1;
        chk("after_hs_outstanding", outstanding, 3'd3);
        chk("fifth_ready", ram_cmd_ready, 1'b1);
        $display("read  id=5 last=1 ready=%0b app_cmd=%0d", ram_cmd_ready, app_cmd);
        step();
        ram_cmd_rd_en = 1'b0;
        #1;
        chk("refill_outstanding", outstanding, 3'd4);
        for (int i = 2; i <= 5; i++) beat(128'(i) * 128'h1000);
        take_resp(4'd2, 128'h2000, 1'b0);
        take_resp(4'd3, 128'h3000, 1'b0);
        take_resp(4'd4, 128'h4000, 1'b1);
        take_resp(4'd5, 128'h5000, 1'b1);
        #1;
        chk("drain_valid", ram_rd_resp_valid, 1'b0);
        chk("drain_outstanding", outstanding, 3'd0);
        chk("drain_err", err, 1'b0);

        // ---- ordering and hold: id 7 (last=0) then id 9 (last=1)
        issue_read(4'd7, 1'b0);
        issue_read(4'd9, 1'b1);
        step();
        app_rd_data_valid = 1'b1;
        app_rd_data       = dat_a;
        #1;
        chk("latency_not_yet", ram_rd_resp_valid, 1'b0);
        step();
        app_rd_data = dat_b;
        #1;
        chk("latency_one", ram_rd_resp_valid, 1'b1);
        step();
        app_rd_data_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("hold_valid", ram_rd_resp_valid, 1'b1);
            chk("hold_id", ram_rd_resp_id, 4'd7);
            chk("hold_data", ram_rd_resp_data, dat_a);
            step();
        end
        take_resp(4'd7, dat_a, 1'b0);
        take_resp(4'd9, dat_b, 1'b1);
        #1;
        chk("order_done_valid", ram_rd_resp_valid, 1'b0);
        chk("order_done_outstanding", outstanding, 3'd0);

        // ---- write waits for the in-flight read to be handed back
        issue_read(4'd3, 1'b0);
        ram_cmd_wr_en   = 1'b1;
        ram_cmd_addr    = 32'h0000_0200;
        ram_cmd_wr_strb = 16'hFFFF;
        #1;
        chk("wwr_blocked", ram_cmd_ready, 1'b0);
        chk("wwr_no_wren", app_wdf_wren, 1'b0);
        step();
        app_rd_data_valid = 1'b1;
        app_rd_data       = 128'h33;
        #1;
        chk("wwr_blocked2", ram_cmd_ready, 1'b0);
        step();
        app_rd_data_valid = 1'b0;
        take_resp(4'd3, 128'h33, 1'b0);
        #1;
        $display("write addr=%0h strb=%0h ready=%0b", ram_cmd_addr, ram_cmd_wr_strb, ram_cmd_ready);
        chk("wwr_ready", ram_cmd_ready, 1'b1);
        chk("wwr_wren", app_wdf_wren, 1'b1);
        step();
        ram_cmd_wr_en = 1'b0;
        #1;
        chk("wwr_err", err, 1'b0);

        // ---- both enables: treated as a write, err sticks until reset
        step();
        ram_cmd_wr_en = 1'b1;
        ram_cmd_rd_en = 1'b1;
        ram_cmd_id    = 4'd6;
        #1;
        $display("both  id=6 ready=%0b app_cmd=%0d", ram_cmd_ready, app_cmd);
        chk("both_ready", ram_cmd_ready, 1'b1);
        chk("both_app_cmd", app_cmd, 3'b000);
        chk("both_wren", app_wdf_wren, 1'b1);
        step();
        idle_inputs();
        #1;
        chk("both_err", err, 1'b1);
        chk("both_no_tag", outstanding, 3'd0);
        beat(128'h66);
        #1;
        chk("both_no_resp", ram_rd_resp_valid, 1'b0);
        repeat (3) step();
        #1;
        chk("err_sticky", err, 1'b1);

        // ---- reset with two reads in flight; late beats are dropped
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("err_cleared", err, 1'b0);
        issue_read(4'd1, 1'b0);
        issue_read(4'd2, 1'b1);
        #1;
        chk("pre_rst_outstanding", outstanding, 3'd2);
        step();
        rst = 1'b1;
        ram_cmd_rd_en = 1'b1;
        #1;
        chk("rst2_ready", ram_cmd_ready, 1'b0);
        chk("rst2_cmd_en", app_cmd_en, 1'b0);
        step();
        rst = 1'b0;
        ram_cmd_rd_en = 1'b0;
        beat(128'hDEAD);
        beat(128'hBEEF);
        #1;
        chk("late_resp_valid", ram_rd_resp_valid, 1'b0);
        chk("late_outstanding", outstanding, 3'd0);
        chk("late_err", err, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Backstop so the run always ends on its own.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule : tb_ddr_cmd_scheduler

// File: doc/ddr_cmd_scheduler.md
DDR_CMD_SCHEDULER -- requirements
Module: ddr_cmd_scheduler

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk (rising edge) and rst; no other clock or reset.
REQ-002 Parameters SHALL be, one per line:
- DATA_WIDTH, 128, data bus width in bits.
- ADDR_WIDTH, 32, byte address width.
- ID_WIDTH, 4, transaction ID width.
- APP_ADDR_WIDTH, 29, width of app_addr.
- ADDR_SHIFT, 0, right shift from byte address to app address.
- DEPTH, 4, maximum reads in flight; power of two, 2 to 16.
- WR_WAIT_RD, 0, 1 = a write stalls while any read is in flight.
REQ-003 Ports SHALL be, one per line:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- ram_cmd_id  in  ID_WIDTH  command ID.
- ram_cmd_addr  in  ADDR_WIDTH  byte address.
- ram_cmd_wr_data  in  DATA_WIDTH  write data.
- ram_cmd_wr_strb  in  DATA_WIDTH/8  byte enables.
- ram_cmd_wr_en  in  1  write request.
- ram_cmd_rd_en  in  1  read request.
- ram_cmd_last  in  1  last beat of burst.
- ram_cmd_ready  out  1  command accepted this cycle.
- ram_rd_resp_id / _data / _last / _valid  out  ID_WIDTH / DATA_WIDTH / 1 / 1  read response.
- ram_rd_resp_ready  in  1  response consumed.
- app_cmd_ready, app_wdf_rdy, init_calib_complete  in  1 each  DDR core status.
- app_cmd  out  3  command code.
- app_cmd_en  out  1  command strobe.
- app_addr  out  APP_ADDR_WIDTH  app address.
- app_wdf_data / _mask / _wren / _end  out  DATA_WIDTH / DATA_WIDTH/8 / 1 / 1  write data channel.
- app_rd_data  in  DATA_WIDTH  read data.
- app_rd_data_valid  in  1  read data strobe.
- outstanding  out  $clog2(DEPTH)+1  credits in use.
- err  out  1  sticky protocol error flag.

Function
REQ-004 A command (wr_en or rd_en high) SHALL be accepted when ram_cmd_ready is high in the same cycle; ram_cmd_ready may depend combinationally on wr_en/rd_en.
REQ-005 Write ready SHALL be: init_calib_complete & app_cmd_ready & app_wdf_rdy, and, when WR_WAIT_RD=1, outstanding==0.
REQ-006 Read ready SHALL be: init_calib_complete & app_cmd_ready & (outstanding < DEPTH).
REQ-007 An accepted write SHALL, in the same cycle, drive app_cmd=000, app_cmd_en=1, app_wdf_wren=1, app_wdf_end=1, app_wdf_data=wr_data and app_wdf_mask=~wr_strb.
REQ-008 An accepted read SHALL, in the same cycle, drive app_cmd=001 and app_cmd_en=1, and push {id,last} into the tag FIFO.
REQ-009 app_addr SHALL equal the low APP_ADDR_WIDTH bits of (ram_cmd_addr >> ADDR_SHIFT).
REQ-010 When no command is accepted, app_cmd_en, app_wdf_wren and app_wdf_end SHALL be 0.
REQ-011 outstanding SHALL increment on read accept and decrement on a response handshake (valid & ready); when both occur in one cycle it SHALL be unchanged.
REQ-012 app_rd_data_valid SHALL push app_rd_data into the data FIFO (capacity DEPTH).
REQ-013 ram_rd_resp_valid SHALL equal data-FIFO not-empty and SHALL rise one cycle after the corresponding app_rd_data_valid (registered FIFO).
REQ-014 _id and _last SHALL come from the tag FIFO head and _data from the data FIFO head; both FIFOs SHALL pop on handshake.
REQ-015 Responses SHALL return in issue order; valid SHALL stay high with stable payload until ready.
REQ-016 If wr_en and rd_en are both high, the command SHALL be treated as a write only and err SHALL set.
REQ-017 If app_rd_data_valid arrives while the number of data-FIFO entries already equals the number of reads in flight, the beat SHALL be dropped and err SHALL set.
REQ-018 err SHALL clear only on rst.
REQ-019 While init_calib_complete=0, no command SHALL be accepted.

Reset
REQ-020 On rst, both FIFOs SHALL flush and outstanding and err SHALL clear.
REQ-021 During rst, ram_cmd_ready, app_cmd_en, app_wdf_wren and ram_rd_resp_valid SHALL be 0.
REQ-022 Read beats still in flight at reset SHALL be dropped under REQ-017.

Structure
REQ-023 Package ddr_sched_pkg SHALL hold APP_CMD_WR=3'b000 and APP_CMD_RD=3'b001.
REQ-024 One sub-module, sync_fifo (parametrised width/depth, registered output, full/empty), SHALL be instantiated twice: tag FIFO and data FIFO.

Verification
REQ-025 Write addr=0x100, strb=0xFFFF, ADDR_SHIFT=0 -> same cycle: app_cmd=000, app_addr=0x100, app_wdf_mask=0x0000, app_wdf_end=1.
REQ-026 Four reads, ids 1..4, DEPTH=4, DDR silent -> outstanding=4; fifth read sees ready=0; after one response handshake it is accepted.
REQ-027 Reads id 7 then id 9; data A then B; resp_ready held low 5 cycles -> id7/A held stable, then id9/B with last preserved.
REQ-028 WR_WAIT_RD=1, one read in flight -> write ready=0 until the response handshake, then ready=1.
REQ-029 wr_en=rd_en=1 -> write issued, no tag pushed, err=1 until rst.
REQ-030 rst asserted with 2 reads in flight, then 2 late app_rd_data_valid beats -> no resp_valid, outstanding=0, err=1.
